// File: rtl/hazard_forward_unit_if.sv
// ID/EX hazard bus: ID-stage operands, downstream write-back candidates,
// and the registered EX operand selects plus the combinational stall.
interface hazard_forward_unit_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2,
  parameter int SW         = $clog2(NUM_STAGES + 2)
);
  logic                         ID_Valid;
  logic                         UseImmed;
  logic [REG_AW-1:0]            ID_Rs;
  logic [REG_AW-1:0]            ID_Rt;
  logic                         Flush;
  logic [NUM_STAGES*REG_AW-1:0] Stg_Rw;
  logic [NUM_STAGES-1:0]        Stg_RegWrite;
  logic [NUM_STAGES-1:0]        Stg_MemRead;
  logic                         Stall;
  logic                         EX_Bubble;
  logic [SW-1:0]                AluOpCtrlA;
  logic [SW-1:0]                AluOpCtrlB;
  logic [SW-1:0]                DataFwdSel;

  modport master (
    output ID_Valid, UseImmed, ID_Rs, ID_Rt, Flush,
    output Stg_Rw, Stg_RegWrite, Stg_MemRead,
    input  Stall, EX_Bubble, AluOpCtrlA, AluOpCtrlB, DataFwdSel
  );

  modport slave (
    input  ID_Valid, UseImmed, ID_Rs, ID_Rt, Flush,
    input  Stg_Rw, Stg_RegWrite, Stg_MemRead,
    output Stall, EX_Bubble, AluOpCtrlA, AluOpCtrlB, DataFwdSel
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall unit at the ID/EX boundary: picks the
// nearest downstream producer for each source and freezes IF/ID for load latency.
module hazard_forward_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input logic                  CLK,
  input logic                  Reset_L,
  hazard_forward_unit_if.slave bus
);
  localparam int SW = $clog2(NUM_STAGES + 2);
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [SW-1:0] RF_SEL   = SW'(NUM_STAGES + 1);
  localparam logic [SW-1:0] IMM_SEL  = SW'(0);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  logic [NUM_STAGES-1:0] hitRs_s;
  logic [NUM_STAGES-1:0] hitRt_s;
  logic [SW-1:0]         selRs_s;
  logic [SW-1:0]         selRt_s;
  logic [SW-1:0]         selB_s;
  logic                  loadRs_s;
  logic                  loadRt_s;
  logic                  hazard_s;
  logic                  stall_s;
  state_t                state_r;
  state_t                stateNext_s;
  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cntNext_s;
  logic [SW-1:0]         aluOpCtrlA_r;
  logic [SW-1:0]         aluOpCtrlB_r;
  logic [SW-1:0]         dataFwdSel_r;
  logic                  exBubble_r;

  // Per-stage address match; register 0 is hardwired and never forwards
  always_comb begin
    hitRs_s = '0;
    hitRt_s = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      hitRs_s[k] = bus.Stg_RegWrite[k]
                 && (bus.Stg_Rw[k*REG_AW +: REG_AW] == bus.ID_Rs)
                 && (bus.ID_Rs != '0);
      hitRt_s[k] = bus.Stg_RegWrite[k]
                 && (bus.Stg_Rw[k*REG_AW +: REG_AW] == bus.ID_Rt)
                 && (bus.ID_Rt != '0);
    end
  end

  // Nearest-producer priority: scan far to near so the nearest hit lands last.
  // The load flag follows the winner only, so shadowed loads are ignored.
  always_comb begin
    selRs_s  = RF_SEL;
    selRt_s  = RF_SEL;
    loadRs_s = 1'b0;
    loadRt_s = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      selRs_s  = hitRs_s[k] ? SW'(k + 1) : selRs_s;
      loadRs_s = hitRs_s[k] ? (bus.Stg_MemRead[k] && (k < LOAD_LAT)) : loadRs_s;
      selRt_s  = hitRt_s[k] ? SW'(k + 1) : selRt_s;
      loadRt_s = hitRt_s[k] ? (bus.Stg_MemRead[k] && (k < LOAD_LAT)) : loadRt_s;
    end
  end

  // Operand select and load-use hazard; Rt always counts because store data needs it
  always_comb begin
    selB_s   = bus.UseImmed ? IMM_SEL : selRt_s;
    hazard_s = bus.ID_Valid && !bus.Flush && (loadRs_s || loadRt_s);
  end

  // Stall FSM state and countdown register
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Stall FSM next-state and stall request
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (hazard_s) begin
          stall_s = 1'b1;
          if (LOAD_LAT > 1) begin
            stateNext_s = STALL;
            cntNext_s   = CNT_LOAD;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      STALL: begin
        if (bus.Flush) begin
          stateNext_s = IDLE;
          cntNext_s   = '0;
        end else begin
          stall_s   = 1'b1;
          cntNext_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            stateNext_s = IDLE;
          end else begin
            stateNext_s = STALL;
          end
        end
      end
      default: begin
        stateNext_s = IDLE;
        cntNext_s   = '0;
      end
    endcase
  end

  // EX-stage operand selects; stalled, squashed or empty slots become bubbles
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      aluOpCtrlA_r <= RF_SEL;
      aluOpCtrlB_r <= RF_SEL;
      dataFwdSel_r <= RF_SEL;
      exBubble_r   <= 1'b1;
    end else if (stall_s || bus.Flush || !bus.ID_Valid) begin
      aluOpCtrlA_r <= RF_SEL;
      aluOpCtrlB_r <= RF_SEL;
      dataFwdSel_r <= RF_SEL;
      exBubble_r   <= 1'b1;
    end else begin
      aluOpCtrlA_r <= selRs_s;
      aluOpCtrlB_r <= selB_s;
      dataFwdSel_r <= selRt_s;
      exBubble_r   <= 1'b0;
    end
  end

  // Stall is held low while reset is asserted even if a hazard is visible
  assign bus.Stall      = stall_s && Reset_L;
  assign bus.AluOpCtrlA = aluOpCtrlA_r;
  assign bus.AluOpCtrlB = aluOpCtrlB_r;
  assign bus.DataFwdSel = dataFwdSel_r;
  assign bus.EX_Bubble  = exBubble_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: a default 2-stage/latency-1 unit and a 4-stage/latency-3 unit.
module tb_hazard_forward_unit;
  logic CLK;
  logic Reset_L;
  int   asserts;
  int   failures;

  hazard_forward_unit_if #(.REG_AW(5), .NUM_STAGES(2)) busA ();
  hazard_forward_unit_if #(.REG_AW(5), .NUM_STAGES(4)) busB ();

  hazard_forward_unit #(.REG_AW(5), .NUM_STAGES(2), .LOAD_LAT(1)) dutA (
    .CLK(CLK), .Reset_L(Reset_L), .bus(busA)
  );
  hazard_forward_unit #(.REG_AW(5), .NUM_STAGES(4), .LOAD_LAT(3)) dutB (
    .CLK(CLK), .Reset_L(Reset_L), .bus(busB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleA();
    busA.ID_Valid = 1'b0; busA.UseImmed = 1'b0; busA.Flush = 1'b0;
    busA.ID_Rs = 5'd0; busA.ID_Rt = 5'd0; busA.Stg_Rw = 10'd0;
    busA.Stg_RegWrite = 2'b00; busA.Stg_MemRead = 2'b00;
  endtask

  task automatic idleB();
    busB.ID_Valid = 1'b0; busB.UseImmed = 1'b0; busB.Flush = 1'b0;
    busB.ID_Rs = 5'd0; busB.ID_Rt = 5'd0; busB.Stg_Rw = 20'd0;
    busB.Stg_RegWrite = 4'b0000; busB.Stg_MemRead = 4'b0000;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    idleA(); idleB();
    repeat (2) @(posedge CLK);
    #1;
    asserts++;
    if ({busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel, busA.EX_Bubble, busA.Stall} !== {2'd3, 2'd3, 2'd3, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_A: got %b expected %b", {busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel, busA.EX_Bubble, busA.Stall}, {2'd3, 2'd3, 2'd3, 1'b1, 1'b0});
    end
    asserts++;
    if ({busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble, busB.Stall} !== {3'd5, 3'd5, 3'd5, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_B: got %b expected %b", {busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble, busB.Stall}, {3'd5, 3'd5, 3'd5, 1'b1, 1'b0});
    end
    Reset_L = 1'b1;
    tick();
  endtask

  task automatic test_forward_priority();
    busA.ID_Valid = 1'b1; busA.ID_Rs = 5'd3; busA.ID_Rt = 5'd0;
    busA.Stg_Rw = {5'd3, 5'd3}; busA.Stg_RegWrite = 2'b11; busA.Stg_MemRead = 2'b00;
    #1;
    asserts++;
    if (busA.Stall !== 1'b0) begin failures++; $display("FAIL nearest_stall: got %b expected 0", busA.Stall); end
    tick();
    asserts++;
    if ({busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel, busA.EX_Bubble} !== {2'd1, 2'd3, 2'd3, 1'b0}) begin
      failures++; $display("FAIL nearest_sel: got %b expected %b", {busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel, busA.EX_Bubble}, {2'd1, 2'd3, 2'd3, 1'b0});
    end
    busA.ID_Rs = 5'd0; busA.ID_Rt = 5'd5; busA.Stg_Rw = {5'd5, 5'd7};
    tick();
    asserts++;
    if ({busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel} !== {2'd3, 2'd2, 2'd2}) begin
      failures++; $display("FAIL rt_stage2: got %b expected %b", {busA.AluOpCtrlA, busA.AluOpCtrlB, busA.DataFwdSel}, {2'd3, 2'd2, 2'd2});
    end
    busA.UseImmed = 1'b1;
    tick();
    asserts++;
    if ({busA.AluOpCtrlB, busA.DataFwdSel} !== {2'd0, 2'd2}) begin
      failures++; $display("FAIL use_immed: got %b expected %b", {busA.AluOpCtrlB, busA.DataFwdSel}, {2'd0, 2'd2});
    end
    busA.UseImmed = 1'b0; busA.ID_Rs = 5'd0; busA.ID_Rt = 5'd0; busA.Stg_Rw = {5'd9, 5'd0};
    tick();
    asserts++;
    if ({busA.AluOpCtrlA, busA.AluOpCtrlB} !== {2'd3, 2'd3}) begin
      failures++; $display("FAIL reg_zero: got %b expected %b", {busA.AluOpCtrlA, busA.AluOpCtrlB}, {2'd3, 2'd3});
    end
    idleA();
  endtask

  task automatic test_load_use();
    busA.ID_Valid = 1'b1; busA.ID_Rs = 5'd4; busA.ID_Rt = 5'd0;
    busA.Stg_Rw = {5'd0, 5'd4}; busA.Stg_RegWrite = 2'b01; busA.Stg_MemRead = 2'b01;
    #1;
    asserts++;
    if (busA.Stall !== 1'b1) begin failures++; $display("FAIL load_use_stall: got %b expected 1", busA.Stall); end
    tick();
    asserts++;
    if ({busA.AluOpCtrlA, busA.EX_Bubble} !== {2'd3, 1'b1}) begin
      failures++; $display("FAIL load_use_bubble: got %b expected %b", {busA.AluOpCtrlA, busA.EX_Bubble}, {2'd3, 1'b1});
    end
    busA.Stg_Rw = {5'd4, 5'd0}; busA.Stg_RegWrite = 2'b10; busA.Stg_MemRead = 2'b10;
    #1;
    asserts++;
    if (busA.Stall !== 1'b0) begin failures++; $display("FAIL load_stage2_stall: got %b expected 0", busA.Stall); end
    tick();
    asserts++;
    if ({busA.AluOpCtrlA, busA.EX_Bubble} !== {2'd2, 1'b0}) begin
      failures++; $display("FAIL load_stage2_fwd: got %b expected %b", {busA.AluOpCtrlA, busA.EX_Bubble}, {2'd2, 1'b0});
    end
    busA.Stg_Rw = {5'd0, 5'd4}; busA.Stg_RegWrite = 2'b01; busA.Stg_MemRead = 2'b01; busA.Flush = 1'b1;
    #1;
    asserts++;
    if (busA.Stall !== 1'b0) begin failures++; $display("FAIL flush_dominates: got %b expected 0", busA.Stall); end
    tick();
    asserts++;
    if (busA.EX_Bubble !== 1'b1) begin failures++; $display("FAIL flush_bubble: got %b expected 1", busA.EX_Bubble); end
    busA.Flush = 1'b0; busA.ID_Valid = 1'b0;
    #1;
    asserts++;
    if (busA.Stall !== 1'b0) begin failures++; $display("FAIL invalid_no_stall: got %b expected 0", busA.Stall); end
    idleA();
    tick();
  endtask

  task automatic test_shadow_and_latency();
    busB.ID_Valid = 1'b1; busB.ID_Rs = 5'd6;
    busB.Stg_Rw = {5'd0, 5'd0, 5'd6, 5'd6}; busB.Stg_RegWrite = 4'b0011; busB.Stg_MemRead = 4'b0010;
    #1;
    asserts++;
    if (busB.Stall !== 1'b0) begin failures++; $display("FAIL shadowed_load: got %b expected 0", busB.Stall); end
    tick();
    asserts++;
    if ({busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel} !== {3'd1, 3'd5, 3'd5}) begin
      failures++; $display("FAIL shadowed_sel: got %b expected %b", {busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel}, {3'd1, 3'd5, 3'd5});
    end
    busB.Stg_Rw = {5'd0, 5'd6, 5'd0, 5'd0}; busB.Stg_RegWrite = 4'b0100; busB.Stg_MemRead = 4'b0100;
    #1;
    asserts++;
    if (busB.Stall !== 1'b1) begin failures++; $display("FAIL load_stage3: got %b expected 1", busB.Stall); end
    busB.Stg_Rw = {5'd6, 5'd0, 5'd0, 5'd0}; busB.Stg_RegWrite = 4'b1000; busB.Stg_MemRead = 4'b1000;
    #1;
    asserts++;
    if (busB.Stall !== 1'b0) begin failures++; $display("FAIL load_stage4: got %b expected 0", busB.Stall); end
    tick();
    asserts++;
    if ({busB.AluOpCtrlA, busB.EX_Bubble} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL load_stage4_fwd: got %b expected %b", {busB.AluOpCtrlA, busB.EX_Bubble}, {3'd4, 1'b0});
    end
    idleB();
    tick();
  endtask

  task automatic hazardB();
    busB.ID_Valid = 1'b1; busB.UseImmed = 1'b1; busB.ID_Rs = 5'd0; busB.ID_Rt = 5'd8;
    busB.Stg_Rw = {5'd0, 5'd0, 5'd0, 5'd8}; busB.Stg_RegWrite = 4'b0001; busB.Stg_MemRead = 4'b0001;
  endtask

  task automatic cleanB();
    busB.Stg_Rw = {5'd8, 5'd0, 5'd0, 5'd0}; busB.Stg_RegWrite = 4'b1000; busB.Stg_MemRead = 4'b0000;
  endtask

  task automatic test_multi_cycle_stall();
    hazardB();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) cleanB();
      #1;
      asserts++;
      if (busB.Stall !== 1'b1) begin failures++; $display("FAIL stall_cycle%0d: got %b expected 1", c, busB.Stall); end
      tick();
    end
    asserts++;
    if ({busB.Stall, busB.EX_Bubble} !== {1'b0, 1'b1}) begin
      failures++; $display("FAIL stall_end: got %b expected %b", {busB.Stall, busB.EX_Bubble}, {1'b0, 1'b1});
    end
    tick();
    asserts++;
    if ({busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble} !== {3'd5, 3'd0, 3'd4, 1'b0}) begin
      failures++; $display("FAIL post_stall_sel: got %b expected %b", {busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble}, {3'd5, 3'd0, 3'd4, 1'b0});
    end
    hazardB();
    tick();
    busB.Flush = 1'b1;
    #1;
    asserts++;
    if (busB.Stall !== 1'b0) begin failures++; $display("FAIL flush_in_stall: got %b expected 0", busB.Stall); end
    tick();
    asserts++;
    if (busB.EX_Bubble !== 1'b1) begin failures++; $display("FAIL flush_stall_bubble: got %b expected 1", busB.EX_Bubble); end
    busB.Flush = 1'b0;
    cleanB();
    #1;
    asserts++;
    if (busB.Stall !== 1'b0) begin failures++; $display("FAIL flush_back_idle: got %b expected 0", busB.Stall); end
    tick();
    asserts++;
    if (busB.EX_Bubble !== 1'b0) begin failures++; $display("FAIL flush_resume: got %b expected 0", busB.EX_Bubble); end
  endtask

  task automatic test_reset_mid_stall();
    hazardB();
    tick();
    Reset_L = 1'b0;
    #1;
    asserts++;
    if ({busB.Stall, busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble} !== {1'b0, 3'd5, 3'd5, 3'd5, 1'b1}) begin
      failures++; $display("FAIL reset_in_stall: got %b expected %b", {busB.Stall, busB.AluOpCtrlA, busB.AluOpCtrlB, busB.DataFwdSel, busB.EX_Bubble}, {1'b0, 3'd5, 3'd5, 3'd5, 1'b1});
    end
    cleanB();
    tick();
    Reset_L = 1'b1;
    #1;
    asserts++;
    if (busB.Stall !== 1'b0) begin failures++; $display("FAIL after_release: got %b expected 0", busB.Stall); end
    tick();
    asserts++;
    if ({busB.Stall, busB.EX_Bubble} !== {1'b0, 1'b0}) begin
      failures++; $display("FAIL no_residual_stall: got %b expected %b", {busB.Stall, busB.EX_Bubble}, {1'b0, 1'b0});
    end
    hazardB();
    #1;
    asserts++;
    if (busB.Stall !== 1'b1) begin failures++; $display("FAIL new_hazard: got %b expected 1", busB.Stall); end
    idleB();
    tick();
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    test_reset();
    test_forward_priority();
    test_load_use();
    test_shadow_and_latency();
    test_multi_cycle_stall();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
